fir_coef_loader: RTL

- Streaming writer that receives filter-coefficient frames over a valid/ready byte interface and drives the H0/H1/H2 coefficient inputs of the 3-tap FIR.
- Double-buffered: bytes fill shadow registers; live coefficients change atomically on a clean frame commit only, so the FIR never sees a partially updated tap set.
- Sits between the host/config path and the FIR coefficient ports.

---
 rtl/fir_coef_loader.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fir_coef_loader.sv
// Double-buffered coefficient loader: byte frames fill shadow taps, which are committed atomically to H0..H2.
// Optional COEF_CHECKSUM_EN appends a mod-2^COEF_W checksum byte to every frame.
module fir_coef_loader #(
   parameter int                COEF_W = 8,
   parameter int                NTAPS  = 3,
   parameter logic [COEF_W-1:0] RST_H0 = COEF_W'(1)
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              In_valid,
   output logic              In_ready,
   input  logic [COEF_W-1:0] In_data,
   input  logic              In_last,
   output logic [COEF_W-1:0] H0,
   output logic [COEF_W-1:0] H1,
   output logic [COEF_W-1:0] H2,
   output logic              Coef_update,
   output logic              Err,
   output logic              Busy
);

`ifdef COEF_CHECKSUM_EN
   localparam int FLEN = NTAPS + 1;
`else
   localparam int FLEN = NTAPS;
`endif
   localparam int CW = $clog2(FLEN + 1);

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, COMMIT} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
   logic [COEF_W-1:0] shadow_q [NTAPS];
   logic [COEF_W-1:0] shadow_d [NTAPS];
   logic [COEF_W-1:0] h_q [NTAPS];
   logic [COEF_W-1:0] h_d [NTAPS];
   logic              upd_q, upd_d;
   logic              err_q, err_d;
   logic              accept;
   logic              csum_ok;

   assign In_ready    = (state_q != COMMIT);
   assign Busy        = (state_q != IDLE);
   assign accept      = In_valid & In_ready;
   assign cnt_inc     = cnt_q + 1'b1;
   assign H0          = h_q[0];
   assign H1          = h_q[1];
   assign H2          = h_q[2];
   assign Coef_update = upd_q;
   assign Err         = err_q;

`ifdef COEF_CHECKSUM_EN
   logic [COEF_W-1:0] csum;

   always_comb begin
      csum = '0;
      for (int i = 0; i < NTAPS; i++) begin
         csum = csum + shadow_q[i];
      end
      csum_ok = (csum == In_data);
   end
`else
   assign csum_ok = 1'b1;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      h_d      = h_q;
      upd_d    = 1'b0;
      err_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (In_last) begin
                  err_d = 1'b1;
               end else begin
                  shadow_d[0] = In_data;
                  cnt_d       = CW'(1);
                  state_d     = LOAD;
               end
            end
         end
         LOAD: begin
            if (accept) begin
               // The checksum byte (count == NTAPS) is compared, never stored.
               for (int i = 0; i < NTAPS; i++) begin
                  if (cnt_q == CW'(i)) shadow_d[i] = In_data;
               end
               cnt_d = cnt_inc;
               if (In_last) begin
                  cnt_d = '0;
                  if ((cnt_inc == CW'(FLEN)) && csum_ok) begin
                     state_d = COMMIT;
                  end else begin
                     err_d    = 1'b1;
                     shadow_d = '{default: '0};
                     state_d  = IDLE;
                  end
               end else if (cnt_inc == CW'(FLEN)) begin
                  cnt_d    = '0;
                  err_d    = 1'b1;
                  shadow_d = '{default: '0};
                  state_d  = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (accept && In_last) begin
               state_d = IDLE;
            end
         end
         COMMIT: begin
            h_d     = shadow_q;
            upd_d   = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         upd_q   <= 1'b0;
         err_q   <= 1'b0;
         for (int i = 0; i < NTAPS; i++) begin
            shadow_q[i] <= '0;
            h_q[i]      <= (i == 0) ? RST_H0 : '0;
         end
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         upd_q    <= upd_d;
         err_q    <= err_d;
         shadow_q <= shadow_d;
         h_q      <= h_d;
      end
   end

endmodule
